// File: rtl/bp_io_cce_arbiter.sv
// Round-robin arbiter that shares one IO command/response channel between LCE requesters; grant to io_cmd_v_o is 1 cycle.
// Grants stall on a busy output register, exhausted credits or a fence; responses wait on the ready of the requester they are steered to.
module bp_io_cce_arbiter #(
    parameter int num_req_p         = 4,
    parameter int msg_width_p       = 128,
    parameter int lce_id_width_p    = 4,
    parameter int max_outstanding_p = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0]         req_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    output logic [num_req_p-1:0]                     req_yumi_o,
    output logic [msg_width_p-1:0]                   io_cmd_o,
    output logic                                     io_cmd_v_o,
    input  logic                                     io_cmd_ready_i,
    input  logic [msg_width_p-1:0]                   io_resp_i,
    input  logic [lce_id_width_p-1:0]                io_resp_lce_id_i,
    input  logic                                     io_resp_v_i,
    output logic                                     io_resp_yumi_o,
    output logic [msg_width_p-1:0]                   resp_o,
    output logic [num_req_p-1:0]                     resp_v_o,
    input  logic [num_req_p-1:0]                     resp_ready_i,
    input  logic                                     fence_i,
    output logic                                     fence_done_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]   credits_o,
    output logic                                     route_err_o
);

    localparam int ptr_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int credit_width_lp = $clog2(max_outstanding_p + 1);
    localparam bit pow2_lp         = ((num_req_p & (num_req_p - 1)) == 0);

    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(max_outstanding_p);
    localparam logic [credit_width_lp-1:0] credit_one_lp = credit_width_lp'(1);
    localparam logic [ptr_width_lp-1:0]    ptr_last_lp   = ptr_width_lp'(num_req_p - 1);
    localparam logic [ptr_width_lp-1:0]    ptr_one_lp    = ptr_width_lp'(1);
    localparam logic [lce_id_width_p-1:0]  num_req_id_lp = lce_id_width_p'(num_req_p);
    localparam logic [num_req_p-1:0]       onehot0_lp    = num_req_p'(1);

    typedef enum logic [1:0] {e_run, e_drain, e_fenced} state_e;

    state_e                       state;
    logic [ptr_width_lp-1:0]      ptr;
    logic [ptr_width_lp-1:0]      winner;
    logic                         any_req;
    logic                         grant;
    logic                         reg_free;
    logic [msg_width_p-1:0]       cmd_r;
    logic                         cmd_v_r;
    logic                         cmd_v_next;
    logic [credit_width_lp-1:0]   credits_r;
    logic [credit_width_lp-1:0]   credits_next;
    logic                         fence_done_r;
    logic                         route_err_r;
    logic [ptr_width_lp-1:0]      resp_idx;
    logic                         routable;

    // Scan downward so the requester closest to the pointer is the last (winning) assignment.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (req_v_i[(int'(ptr) + i) % num_req_p]) begin
                winner  = ptr_width_lp'((int'(ptr) + i) % num_req_p);
                any_req = 1'b1;
            end
        end
    end

    assign reg_free   = !cmd_v_r || io_cmd_ready_i;
    assign grant      = (state == e_run) && !fence_i && reg_free && (credits_r < credit_max_lp) && any_req;
    assign req_yumi_o = grant ? (onehot0_lp << winner) : '0;
    assign cmd_v_next = grant || (cmd_v_r && !io_cmd_ready_i);

    // Non-power-of-two counts cannot fold the id, so out-of-range ids are dropped but still return a credit.
    assign resp_idx       = io_resp_lce_id_i[ptr_width_lp-1:0];
    assign routable       = pow2_lp || (io_resp_lce_id_i < num_req_id_lp);
    assign resp_v_o       = (io_resp_v_i && routable) ? (onehot0_lp << resp_idx) : '0;
    assign io_resp_yumi_o = io_resp_v_i && (!routable || resp_ready_i[resp_idx]);
    assign resp_o         = io_resp_i;

    always_comb begin
        credits_next = credits_r;
        if (grant && !io_resp_yumi_o)
            credits_next = credits_r + credit_one_lp;
        else if (!grant && io_resp_yumi_o && (credits_r != '0))
            credits_next = credits_r - credit_one_lp;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_r       <= '0;
            cmd_v_r     <= 1'b0;
            credits_r   <= '0;
            ptr         <= '0;
            route_err_r <= 1'b0;
        end else begin
            if (grant) begin
                cmd_r <= req_i[winner*msg_width_p +: msg_width_p];
                ptr   <= (winner == ptr_last_lp) ? '0 : winner + ptr_one_lp;
            end
            cmd_v_r     <= cmd_v_next;
            credits_r   <= credits_next;
            route_err_r <= io_resp_v_i && !routable;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= e_run;
            fence_done_r <= 1'b0;
        end else begin
            case (state)
                e_run: begin
                    if (fence_i)
                        state <= e_drain;
                end
                e_drain: begin
                    if (!fence_i) begin
                        state <= e_run;
                    end else if (!cmd_v_next && (credits_next == '0)) begin
                        state        <= e_fenced;
                        fence_done_r <= 1'b1;
                    end
                end
                e_fenced: begin
                    if (!fence_i) begin
                        state        <= e_run;
                        fence_done_r <= 1'b0;
                    end
                end
                default: begin
                    state        <= e_run;
                    fence_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign io_cmd_o     = cmd_r;
    assign io_cmd_v_o   = cmd_v_r;
    assign credits_o    = credits_r;
    assign fence_done_o = fence_done_r;
    assign route_err_o  = route_err_r;

endmodule

// File: tb/tb_bp_io_cce_arbiter.sv
// Directed bench for bp_io_cce_arbiter: round-robin order, credit cap, stall, fence drain and async reset.
module tb_bp_io_cce_arbiter;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic [511:0]   req_i;
    logic [3:0]     req_v_i;
    logic [3:0]     req_yumi_o;
    logic [127:0]   io_cmd_o;
    logic           io_cmd_v_o;
    logic           io_cmd_ready_i;
    logic [127:0]   io_resp_i;
    logic [3:0]     io_resp_lce_id_i;
    logic           io_resp_v_i;
    logic           io_resp_yumi_o;
    logic [127:0]   resp_o;
    logic [3:0]     resp_v_o;
    logic [3:0]     resp_ready_i;
    logic           fence_i;
    logic           fence_done_o;
    logic [3:0]     credits_o;
    logic           route_err_o;

    int vectors     = 0;
    int miscompares = 0;

    bp_io_cce_arbiter #(
        .num_req_p(4), .msg_width_p(128), .lce_id_width_p(4), .max_outstanding_p(8)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_i(req_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
        .io_resp_i(io_resp_i), .io_resp_lce_id_i(io_resp_lce_id_i), .io_resp_v_i(io_resp_v_i),
        .io_resp_yumi_o(io_resp_yumi_o),
        .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
        .fence_i(fence_i), .fence_done_o(fence_done_o),
        .credits_o(credits_o), .route_err_o(route_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] msg(input int k);
        return {96'h0, 32'hC0DE_0000 + 32'(k)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i        = 1'b0;
        req_v_i          = '0;
        io_cmd_ready_i   = 1'b0;
        io_resp_i        = '0;
        io_resp_lce_id_i = '0;
        io_resp_v_i      = 1'b0;
        resp_ready_i     = '0;
        fence_i          = 1'b0;
        for (int k = 0; k < 4; k++) req_i[k*128 +: 128] = msg(k);

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cmd_v", io_cmd_v_o, 0);
        chk("rst_cmd", io_cmd_o, 0);
        chk("rst_credits", credits_o, 0);
        chk("rst_fence_done", fence_done_o, 0);
        chk("rst_route_err", route_err_o, 0);
        reset_n_i = 1'b1;

        // Round-robin fill up to the credit cap.
        req_v_i        = 4'b1111;
        io_cmd_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", req_yumi_o, 4'b0001 << (c % 4));
            chk("rr_credits", credits_o, c);
            if (c > 0) chk("rr_cmd", io_cmd_o, msg((c - 1) % 4));
            next_cycle();
        end
        #1;
        chk("cap_credits", credits_o, 8);
        chk("cap_grant", req_yumi_o, 0);
        chk("cap_cmd", io_cmd_o, msg(3));
        chk("cap_cmd_v", io_cmd_v_o, 1);
        next_cycle();

        io_resp_v_i      = 1'b1;
        io_resp_lce_id_i = 4'd2;
        io_resp_i        = 128'hBEEF;
        resp_ready_i     = 4'b0100;
        #1;
        chk("drained_cmd_v", io_cmd_v_o, 0);
        chk("cap_grant2", req_yumi_o, 0);
        chk("route_v", resp_v_o, 4'b0100);
        chk("route_yumi", io_resp_yumi_o, 1);
        chk("route_data", resp_o, 128'hBEEF);
        next_cycle();

        io_resp_v_i = 1'b0;
        #1;
        chk("resp_credits", credits_o, 7);
        chk("one_grant", req_yumi_o, 4'b0001);
        chk("route_idle", resp_v_o, 0);
        next_cycle();

        // Stall the IO side; return three credits meanwhile.
        req_v_i          = 4'b0000;
        io_cmd_ready_i   = 1'b0;
        io_resp_v_i      = 1'b1;
        io_resp_lce_id_i = 4'd1;
        resp_ready_i     = 4'b1111;
        #1;
        chk("one_grant_credits", credits_o, 8);
        chk("one_grant_cmd", io_cmd_o, msg(0));
        chk("route_v1", resp_v_o, 4'b0010);
        next_cycle();
        next_cycle();
        next_cycle();

        io_resp_v_i = 1'b0;
        req_v_i     = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_grant", req_yumi_o, 0);
            chk("stall_cmd", io_cmd_o, msg(0));
            chk("stall_cmd_v", io_cmd_v_o, 1);
            chk("stall_credits", credits_o, 5);
            next_cycle();
        end

        io_cmd_ready_i = 1'b1;
        #1;
        chk("unstall_grant", req_yumi_o, 4'b0010);
        next_cycle();

        req_v_i          = 4'b0000;
        io_resp_v_i      = 1'b1;
        io_resp_lce_id_i = 4'd0;
        #1;
        chk("unstall_credits", credits_o, 6);
        chk("unstall_cmd", io_cmd_o, msg(1));
        next_cycle();
        next_cycle();
        next_cycle();

        // Grant and response in the same cycle.
        req_v_i          = 4'b0100;
        io_resp_lce_id_i = 4'd3;
        #1;
        chk("same_pre_credits", credits_o, 3);
        chk("same_grant", req_yumi_o, 4'b0100);
        chk("same_resp_yumi", io_resp_yumi_o, 1);
        next_cycle();

        req_v_i          = 4'b0000;
        io_resp_lce_id_i = 4'd0;
        #1;
        chk("same_credits", credits_o, 3);
        chk("same_cmd", io_cmd_o, msg(2));
        next_cycle();

        // Fence with two outstanding.
        io_resp_v_i = 1'b0;
        fence_i     = 1'b1;
        req_v_i     = 4'b1111;
        #1;
        chk("fence_credits", credits_o, 2);
        chk("fence_cmd_v", io_cmd_v_o, 0);
        chk("fence_first_grant", req_yumi_o, 0);
        chk("fence_done0", fence_done_o, 0);
        next_cycle();
        #1;
        chk("drain_grant", req_yumi_o, 0);
        chk("drain_done0", fence_done_o, 0);
        next_cycle();

        io_resp_v_i      = 1'b1;
        io_resp_lce_id_i = 4'd1;
        #1;
        chk("drain_done1", fence_done_o, 0);
        next_cycle();

        io_resp_lce_id_i = 4'd2;
        #1;
        chk("drain_credits1", credits_o, 1);
        chk("drain_done2", fence_done_o, 0);
        next_cycle();

        io_resp_v_i = 1'b0;
        #1;
        chk("fenced_done", fence_done_o, 1);
        chk("fenced_credits", credits_o, 0);
        chk("fenced_grant", req_yumi_o, 0);
        next_cycle();

        fence_i = 1'b0;
        #1;
        chk("unfence_grant", req_yumi_o, 0);
        chk("unfence_done", fence_done_o, 1);
        next_cycle();
        #1;
        chk("resume_done", fence_done_o, 0);
        chk("resume_grant", req_yumi_o, 4'b1000);
        next_cycle();

        for (int c = 0; c < 4; c++) begin
            #1;
            chk("refill_grant", req_yumi_o, 4'b0001 << c);
            chk("refill_credits", credits_o, 1 + c);
            next_cycle();
        end

        // Asynchronous reset mid-transaction.
        req_v_i        = 4'b0000;
        io_cmd_ready_i = 1'b0;
        #1;
        chk("pre_rst_credits", credits_o, 5);
        chk("pre_rst_cmd_v", io_cmd_v_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("arst_cmd_v", io_cmd_v_o, 0);
        chk("arst_credits", credits_o, 0);
        chk("arst_fence_done", fence_done_o, 0);
        chk("arst_cmd", io_cmd_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
